// File: rtl/snn_cg_ctrl.sv
// snn_cg_ctrl: frame sequencer for a 2-image 6x6 SNN pipeline, issuing load strobes and conv/pool/fc fire pulses.
// Stage clock-gate sleep requests are generated only when SNN_CG_CTRL_SLEEP_EN is defined (tied 0 otherwise).
module snn_cg_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic [2:0] pix_x,
  output logic [2:0] pix_y,
  output logic       img_sel,
  output logic       ker_we,
  output logic [3:0] ker_idx,
  output logic       wgt_we,
  output logic [1:0] wgt_idx,
  output logic       conv_go,
  output logic       pool_go,
  output logic       fc_go,
  output logic       out_fire,
  output logic       conv_sleep,
  output logic       pool_sleep,
  output logic       fc_sleep,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  state_t     state_q, state_d;
  logic [6:0] beat_q, beat_d;
  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic       img_q, img_d;
  logic [1:0] drn_q, drn_d;

  logic accept, last_beat;
  logic conv_pre, pool_pre, fc_pre, out_pre;
  logic conv_go_q, conv_pc_q, conv_fc_q, conv_img_q;
  logic pool_go_q, pool_fc_q, pool_img_q;
  logic fc_go_q, fc_img_q;
  logic out_fire_q;

  assign accept    = in_valid && !rst && (state_q == IDLE || state_q == LOAD);
  assign last_beat = (beat_q == 7'd71);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    x_d     = x_q;
    y_d     = y_q;
    img_d   = img_q;
    drn_d   = drn_q;
    if (accept) begin
      beat_d = last_beat ? 7'd0 : beat_q + 7'd1;
      x_d    = (x_q == 3'd5) ? 3'd0 : x_q + 3'd1;
      if (x_q == 3'd5) begin
        y_d = (y_q == 3'd5) ? 3'd0 : y_q + 3'd1;
        if (y_q == 3'd5) img_d = !img_q;
      end
    end
    case (state_q)
      IDLE:  if (accept) state_d = LOAD;
      LOAD:  if (accept && last_beat) begin
               state_d = DRAIN;
               drn_d   = 2'd0;
             end
      // Three drain cycles let the last beat ripple through conv, pool and fc.
      DRAIN: begin
               drn_d = drn_q + 2'd1;
               if (drn_q == 2'd2) state_d = OUT;
             end
      OUT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 7'd0;
      x_q     <= 3'd0;
      y_q     <= 3'd0;
      img_q   <= 1'b0;
      drn_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      x_q     <= x_d;
      y_q     <= y_d;
      img_q   <= img_d;
      drn_q   <= drn_d;
    end
  end

  // Stage pipeline: each stage carries forward the qualifiers of the beat that fired it.
  assign conv_pre = accept && (x_q >= 3'd2) && (y_q >= 3'd2);
  assign pool_pre = conv_go_q && conv_pc_q;
  assign fc_pre   = pool_go_q && pool_fc_q;
  assign out_pre  = fc_go_q && fc_img_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_go_q  <= 1'b0;
      conv_pc_q  <= 1'b0;
      conv_fc_q  <= 1'b0;
      conv_img_q <= 1'b0;
      pool_go_q  <= 1'b0;
      pool_fc_q  <= 1'b0;
      pool_img_q <= 1'b0;
      fc_go_q    <= 1'b0;
      fc_img_q   <= 1'b0;
      out_fire_q <= 1'b0;
    end else begin
      conv_go_q  <= conv_pre;
      conv_pc_q  <= (x_q == 3'd3 || x_q == 3'd5) && (y_q == 3'd3 || y_q == 3'd5);
      conv_fc_q  <= (x_q == 3'd5) && (y_q == 3'd5);
      conv_img_q <= img_q;
      pool_go_q  <= pool_pre;
      pool_fc_q  <= conv_fc_q;
      pool_img_q <= conv_img_q;
      fc_go_q    <= fc_pre;
      fc_img_q   <= pool_img_q;
      out_fire_q <= out_pre;
    end
  end

  assign pix_x    = x_q;
  assign pix_y    = y_q;
  assign img_sel  = img_q;
  assign ker_we   = accept && (beat_q < 7'd9);
  assign ker_idx  = ker_we ? beat_q[3:0] : 4'd0;
  assign wgt_we   = accept && (beat_q < 7'd4);
  assign wgt_idx  = wgt_we ? beat_q[1:0] : 2'd0;
  assign conv_go  = conv_go_q;
  assign pool_go  = pool_go_q;
  assign fc_go    = fc_go_q;
  assign out_fire = out_fire_q;
  assign busy     = (state_q != IDLE);

`ifdef SNN_CG_CTRL_SLEEP_EN
  // A stage wakes the cycle before its fire pulse and stays awake while firing.
  assign conv_sleep = !(conv_pre || conv_go_q);
  assign pool_sleep = !(pool_pre || pool_go_q);
  assign fc_sleep   = !(fc_pre || fc_go_q);
`else
  assign conv_sleep = 1'b0;
  assign pool_sleep = 1'b0;
  assign fc_sleep   = 1'b0;
`endif

endmodule

// File: tb/tb_snn_cg_ctrl.sv
// tb_snn_cg_ctrl: directed bench for snn_cg_ctrl; table of load/decode vectors plus frame-level sequences.
// Expected sleep level in idle follows SNN_CG_CTRL_SLEEP_EN.
module tb_snn_cg_ctrl;

`ifdef SNN_CG_CTRL_SLEEP_EN
  localparam int SLP_IDLE = 1;
`else
  localparam int SLP_IDLE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] pix_x, pix_y;
  logic       img_sel;
  logic       ker_we, wgt_we;
  logic [3:0] ker_idx;
  logic [1:0] wgt_idx;
  logic       conv_go, pool_go, fc_go, out_fire;
  logic       conv_sleep, pool_sleep, fc_sleep, busy;

  snn_cg_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .pix_x(pix_x), .pix_y(pix_y), .img_sel(img_sel),
    .ker_we(ker_we), .ker_idx(ker_idx), .wgt_we(wgt_we), .wgt_idx(wgt_idx),
    .conv_go(conv_go), .pool_go(pool_go), .fc_go(fc_go), .out_fire(out_fire),
    .conv_sleep(conv_sleep), .pool_sleep(pool_sleep), .fc_sleep(fc_sleep),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int n_conv = 0, n_pool = 0, n_fc = 0, n_out = 0;

  typedef struct {
    logic r; logic v; int busy; int kwe; int kidx; int wwe; int widx; int px; int py;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(input logic r, input logic v, input int b, input int kwe, input int kidx,
                              input int wwe, input int widx, input int px, input int py);
    vec_t t;
    t.r = r; t.v = v; t.busy = b; t.kwe = kwe; t.kidx = kidx;
    t.wwe = wwe; t.widx = widx; t.px = px; t.py = py;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs shortly after the rising edge, return at the falling edge for sampling.
  task automatic cyc(input logic r, input logic v);
    @(posedge clk);
    #2;
    rst = r;
    in_valid = v;
    #3;
    n_conv += int'(conv_go);
    n_pool += int'(pool_go);
    n_fc   += int'(fc_go);
    n_out  += int'(out_fire);
  endtask

  task automatic clr_counts();
    n_conv = 0; n_pool = 0; n_fc = 0; n_out = 0;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 1, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 1, 1, 1, 1, 1, 0);
    tbl[3]  = mk(0, 1, 1, 1, 2, 1, 2, 2, 0);
    tbl[4]  = mk(0, 1, 1, 1, 3, 1, 3, 3, 0);
    tbl[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 1, 4, 0, 0, 4, 0);
    tbl[7]  = mk(0, 1, 1, 1, 5, 0, 0, 5, 0);
    tbl[8]  = mk(0, 1, 1, 1, 6, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 1, 1, 7, 0, 0, 1, 1);
    tbl[10] = mk(0, 1, 1, 1, 8, 0, 0, 2, 1);
    tbl[11] = mk(0, 1, 1, 0, 0, 0, 0, 3, 1);
    tbl[12] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 1, 0, 1, 0, 0, 0);

    // Load strobes, decode, reset state and reset priority.
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].v);
      chk($sformatf("row%0d_busy", i), int'(busy), tbl[i].busy);
      chk($sformatf("row%0d_ker_we", i), int'(ker_we), tbl[i].kwe);
      chk($sformatf("row%0d_ker_idx", i), int'(ker_idx), tbl[i].kidx);
      chk($sformatf("row%0d_wgt_we", i), int'(wgt_we), tbl[i].wwe);
      chk($sformatf("row%0d_wgt_idx", i), int'(wgt_idx), tbl[i].widx);
      chk($sformatf("row%0d_conv_go", i), int'(conv_go), 0);
      chk($sformatf("row%0d_conv_sleep", i), int'(conv_sleep), SLP_IDLE);
      if (tbl[i].v && !tbl[i].r) begin
        chk($sformatf("row%0d_pix_x", i), int'(pix_x), tbl[i].px);
        chk($sformatf("row%0d_pix_y", i), int'(pix_y), tbl[i].py);
        chk($sformatf("row%0d_img", i), int'(img_sel), 0);
      end
    end

    // Full back-to-back frame with in_valid held high through drain/out, then frame 2 beat 0.
    cyc(1, 0);
    clr_counts();
    for (int k = 0; k < 72; k++) begin
      cyc(0, 1);
      if (k == 71) begin
        chk("t_busy", int'(busy), 1);
        chk("t_pix_x", int'(pix_x), 5);
        chk("t_pix_y", int'(pix_y), 5);
        chk("t_img", int'(img_sel), 1);
        chk("t_conv_sleep", int'(conv_sleep), 0);
      end
    end
    cyc(0, 1);
    chk("t1_conv_go", int'(conv_go), 1);
    chk("t1_pool_go", int'(pool_go), 0);
    chk("t1_ker_we", int'(ker_we), 0);
    chk("t1_wgt_we", int'(wgt_we), 0);
    chk("t1_busy", int'(busy), 1);
    chk("t1_conv_sleep", int'(conv_sleep), 0);
    chk("t1_pool_sleep", int'(pool_sleep), 0);
    cyc(0, 1);
    chk("t2_pool_go", int'(pool_go), 1);
    chk("t2_conv_go", int'(conv_go), 0);
    chk("t2_ker_we", int'(ker_we), 0);
    chk("t2_conv_sleep", int'(conv_sleep), SLP_IDLE);
    chk("t2_pool_sleep", int'(pool_sleep), 0);
    chk("t2_fc_sleep", int'(fc_sleep), 0);
    cyc(0, 1);
    chk("t3_fc_go", int'(fc_go), 1);
    chk("t3_out_fire", int'(out_fire), 0);
    chk("t3_busy", int'(busy), 1);
    chk("t3_pool_sleep", int'(pool_sleep), SLP_IDLE);
    chk("t3_fc_sleep", int'(fc_sleep), 0);
    cyc(0, 1);
    chk("t4_out_fire", int'(out_fire), 1);
    chk("t4_fc_go", int'(fc_go), 0);
    chk("t4_busy", int'(busy), 1);
    chk("t4_ker_we", int'(ker_we), 0);
    chk("t4_fc_sleep", int'(fc_sleep), SLP_IDLE);
    cyc(0, 1);
    chk("t5_busy", int'(busy), 0);
    chk("t5_out_fire", int'(out_fire), 0);
    chk("t5_ker_we", int'(ker_we), 1);
    chk("t5_ker_idx", int'(ker_idx), 0);
    chk("t5_pix_x", int'(pix_x), 0);
    chk("t5_pix_y", int'(pix_y), 0);
    chk("t5_img", int'(img_sel), 0);
    chk("frame_conv_cnt", n_conv, 32);
    chk("frame_pool_cnt", n_pool, 8);
    chk("frame_fc_cnt", n_fc, 2);
    chk("frame_out_cnt", n_out, 1);
    cyc(0, 0);
    chk("t6_busy", int'(busy), 1);
    chk("t6_pix_x", int'(pix_x), 1);

    // Gap after beat 20, then abort with reset at beat 40.
    cyc(1, 0);
    clr_counts();
    for (int k = 0; k <= 20; k++) cyc(0, 1);
    for (int g = 0; g < 5; g++) begin
      cyc(0, 0);
      chk($sformatf("gap%0d_conv_go", g), int'(conv_go), (g == 0) ? 1 : 0);
      chk($sformatf("gap%0d_busy", g), int'(busy), 1);
    end
    cyc(0, 1);
    chk("b21_pix_x", int'(pix_x), 3);
    chk("b21_pix_y", int'(pix_y), 3);
    chk("b21_img", int'(img_sel), 0);
    for (int k = 22; k < 40; k++) begin
      cyc(0, 1);
      if (k == 36) begin
        chk("b36_img", int'(img_sel), 1);
        chk("b36_pix_x", int'(pix_x), 0);
        chk("b36_pix_y", int'(pix_y), 0);
      end
    end
    chk("pre_abort_conv_cnt", n_conv, 16);
    chk("pre_abort_fc_cnt", n_fc, 1);
    cyc(1, 1);
    clr_counts();
    for (int c = 0; c < 5; c++) begin
      cyc(0, 0);
      chk($sformatf("abort%0d_busy", c), int'(busy), 0);
    end
    chk("abort_pulses", n_conv + n_pool + n_fc + n_out, 0);
    cyc(0, 1);
    chk("restart_pix_x", int'(pix_x), 0);
    chk("restart_pix_y", int'(pix_y), 0);
    chk("restart_img", int'(img_sel), 0);
    chk("restart_ker_we", int'(ker_we), 1);
    cyc(0, 0);
    chk("restart_busy", int'(busy), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
